// File: rtl/lly_seq_tx.sv
// lly_seq_tx: serial pattern transmitter, MSB-first, gapless streaming,
// with a saturating overlapping "0101" occurrence counter on its own line.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   din        - parallel word to transmit (WIDTH bits)
//   in_valid   - din is valid
//   in_ready   - word can be accepted this cycle (from state/bit_cnt only)
//   cnt_clr    - synchronous clear of pat_cnt and the line history
//   dataout    - registered serial line
//   busy       - a word is on the line
//   frame_done - high while the LSB of a word is on the line
//   pat_cnt    - number of "0101" windows driven on dataout (saturating)

module lly_seq_tx #(
    parameter int   WIDTH      = 8,
    parameter int   CNT_W      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cnt_clr,
    output logic             dataout,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] pat_cnt
);

    localparam int BW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [BW-1:0] LAST   = BW'(WIDTH - 1);
    localparam logic [BW-1:0] PENULT = BW'(WIDTH - 2);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    // r_shreg holds the bits still to come; the bit on the line
    // lives in r_dout, so the MSB is already out on the load edge.
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nx;
    // Index of the bit currently on the line (0 = MSB).
    logic [BW-1:0]      r_bit_cnt;
    logic [BW-1:0]      w_bit_cnt_nx;
    logic               r_dout;
    logic               w_dout_nx;
    logic               r_fd;
    logic               w_fd_nx;
    logic               w_last;

    logic [2:0]         r_hist;
    logic [CNT_W-1:0]   r_pat;
    logic               w_hit;
    logic               w_sat;

    // ------------------------------------------------------------
    // State register
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_dout    <= IDLE_LEVEL;
            r_fd      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_shreg   <= w_shreg_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_dout    <= w_dout_nx;
            r_fd      <= w_fd_nx;
        end
    end

    // ------------------------------------------------------------
    // Next-state and handshake logic
    // ------------------------------------------------------------
    always_comb begin
        w_state_nx   = r_state;
        w_shreg_nx   = r_shreg;
        w_bit_cnt_nx = r_bit_cnt;
        w_dout_nx    = r_dout;
        w_fd_nx      = 1'b0;

        w_last   = (r_state == S_SHIFT) && (r_bit_cnt == LAST);
        in_ready = (r_state == S_IDLE) || w_last;

        unique case (r_state)
            S_IDLE: begin
                w_dout_nx = IDLE_LEVEL;
                if (in_valid) begin
                    w_state_nx   = S_SHIFT;
                    w_dout_nx    = din[WIDTH-1];
                    w_shreg_nx   = {din[WIDTH-2:0], 1'b0};
                    w_bit_cnt_nx = '0;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    if (in_valid) begin
                        // Reload on the LSB cycle: no idle bit.
                        w_dout_nx    = din[WIDTH-1];
                        w_shreg_nx   = {din[WIDTH-2:0], 1'b0};
                        w_bit_cnt_nx = '0;
                    end else begin
                        w_state_nx   = S_IDLE;
                        w_dout_nx    = IDLE_LEVEL;
                        w_bit_cnt_nx = '0;
                    end
                end else begin
                    w_dout_nx    = r_shreg[WIDTH-1];
                    w_shreg_nx   = {r_shreg[WIDTH-2:0], 1'b0};
                    w_bit_cnt_nx = r_bit_cnt + BW'(1);
                    // Next bit on the line will be the LSB.
                    w_fd_nx      = (r_bit_cnt == PENULT);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_dout_nx  = IDLE_LEVEL;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Pattern counter over the line as actually driven
    // ------------------------------------------------------------
    assign w_hit = ({r_hist, r_dout} == 4'b0101);
    assign w_sat = &r_pat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_pat  <= '0;
        end else if (cnt_clr) begin
            r_hist <= '0;
            r_pat  <= '0;
        end else begin
            r_hist <= {r_hist[1:0], r_dout};
            if (w_hit && !w_sat) begin
                r_pat <= r_pat + CNT_W'(1);
            end
        end
    end

    assign dataout    = r_dout;
    assign busy       = (r_state == S_SHIFT);
    assign frame_done = r_fd;
    assign pat_cnt    = r_pat;

endmodule

// File: tb/tb_lly_seq_tx.sv
// tb_lly_seq_tx: randomized and directed checks of lly_seq_tx
// against a bit-queue reference model of the serial line.

module tb_lly_seq_tx;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = '0;
    logic       in_valid = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       in_ready, dataout, busy, frame_done;
    logic [7:0] pat_cnt;
    logic       in_ready2, dataout2, busy2, frame_done2;
    logic [1:0] pat_cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lly_seq_tx #(
        .WIDTH(WIDTH), .CNT_W(8), .IDLE_LEVEL(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .din(din),
        .in_valid(in_valid), .in_ready(in_ready),
        .cnt_clr(cnt_clr), .dataout(dataout),
        .busy(busy), .frame_done(frame_done),
        .pat_cnt(pat_cnt)
    );

    lly_seq_tx #(
        .WIDTH(WIDTH), .CNT_W(2), .IDLE_LEVEL(1'b0)
    ) u_sat (
        .clk(clk), .rst(rst), .din(din),
        .in_valid(in_valid), .in_ready(in_ready2),
        .cnt_clr(cnt_clr), .dataout(dataout2),
        .busy(busy2), .frame_done(frame_done2),
        .pat_cnt(pat_cnt2)
    );

    // Reference: queue of {last, bit} items still to appear on the line.
    logic [1:0]  pend[$];
    logic        m_line, m_busy, m_fd;
    logic [2:0]  m_hist;
    int          m_cnt;
    logic [13:0] m_exp;

    function automatic logic [13:0] obs();
        return {in_ready, dataout, busy, frame_done,
                pat_cnt, pat_cnt2};
    endfunction

    task automatic model_reset();
        pend.delete();
        m_line = 1'b0;
        m_busy = 1'b0;
        m_fd   = 1'b0;
        m_hist = '0;
        m_cnt  = 0;
    endtask

    task automatic calc_exp();
        m_exp = {pend.size() == 0, m_line, m_busy, m_fd,
                 8'(m_cnt > 255 ? 255 : m_cnt),
                 2'(m_cnt > 3 ? 3 : m_cnt)};
    endtask

    task automatic cycle();
        logic [1:0] w;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (cnt_clr) begin
                m_cnt  = 0;
                m_hist = '0;
            end else begin
                if ({m_hist, m_line} == 4'b0101) m_cnt++;
                m_hist = {m_hist[1:0], m_line};
            end
            if (in_valid && pend.size() == 0)
                for (int i = WIDTH - 1; i >= 0; i--)
                    pend.push_back({1'(i == 0), din[i]});
            if (pend.size() > 0) begin
                w = pend.pop_front();
                m_line = w[0];
                m_fd   = w[1];
                m_busy = 1'b1;
            end else begin
                m_line = 1'b0;
                m_fd   = 1'b0;
                m_busy = 1'b0;
            end
        end
        calc_exp();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL reset_hold c%0d got %h want %h",
                         c, obs(), m_exp);
            end
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({dataout, busy, in_ready, pat_cnt} !== 11'b00100000000) begin
            n_err++;
            $display("FAIL reset_release got %b want %b",
                     {dataout, busy, in_ready, pat_cnt}, 11'b00100000000);
        end
        din = 8'hFF;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL reset_pre c%0d got %h want %h",
                         c, obs(), m_exp);
            end
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({dataout, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_async got %b want 00",
                     {dataout, busy});
        end
        model_reset();
        cycle();
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cycle();
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL reset_noresume c%0d got %h want %h",
                         c, obs(), m_exp);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0]  bits;
        logic [12:0] fdm, bsm;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        din = 8'h55;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 8) bits = {bits[6:0], dataout};
            fdm[c] = frame_done;
            bsm[c] = busy;
            cycle();
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL single c%0d got %h want %h",
                         c, obs(), m_exp);
            end
        end
        n_vec++;
        if (bits !== 8'h55) begin
            n_err++;
            $display("FAIL single_bits got %h want 55", bits);
        end
        n_vec++;
        if (fdm[12:1] !== 12'h080 || bsm[9] !== 1'b0) begin
            n_err++;
            $display("FAIL single_fd got %h/%b want 080/0",
                     fdm[12:1], bsm[9]);
        end
        n_vec++;
        if (pat_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL single_cnt got %0d want 3", pat_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        logic [20:0] fdm;
        int acc;
        logic a;
        acc = 0;
        fdm = '0;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        din = 8'h55;
        in_valid = 1'b1;
        cycle();
        din = 8'h50;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 16) bits = {bits[14:0], dataout};
            fdm[c] = frame_done;
            a = in_valid && in_ready;
            if (a) acc = c;
            cycle();
            if (a) in_valid = 1'b0;
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL b2b c%0d got %h want %h",
                         c, obs(), m_exp);
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (acc !== 8 || bits !== 16'h5550) begin
            n_err++;
            $display("FAIL b2b_stream got acc=%0d bits=%h want 8/5550",
                     acc, bits);
        end
        n_vec++;
        if (fdm[20:1] !== 20'h08080) begin
            n_err++;
            $display("FAIL b2b_fd got %h want 08080", fdm[20:1]);
        end
        n_vec++;
        if (pat_cnt !== 8'd5) begin
            n_err++;
            $display("FAIL b2b_cnt got %0d want 5", pat_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] bits, bsm;
        int acc;
        logic a;
        acc = 0;
        din = 8'h3C;
        in_valid = 1'b1;
        cycle();
        din = 8'hFF;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 16) begin
                bits = {bits[14:0], dataout};
                bsm  = {bsm[14:0], busy};
            end
            a = in_valid && in_ready;
            if (a) acc = c;
            cycle();
            if (a) in_valid = 1'b0;
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL bp c%0d got %h want %h",
                         c, obs(), m_exp);
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (acc !== 8 || bits !== 16'h3CFF || bsm !== 16'hFFFF) begin
            n_err++;
            $display("FAIL bp_stream got %0d/%h/%h want 8/3CFF/FFFF",
                     acc, bits, bsm);
        end
    endtask

    task automatic send_55(input string nm);
        din = 8'h55;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL %s c%0d got %h want %h",
                         nm, c, obs(), m_exp);
            end
        end
    endtask

    task automatic test_sat_clear();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        send_55("sat_a");
        send_55("sat_b");
        n_vec++;
        if (pat_cnt2 !== 2'd3 || pat_cnt !== 8'd6) begin
            n_err++;
            $display("FAIL sat got %0d/%0d want 3/6",
                     pat_cnt2, pat_cnt);
        end
        din = 8'h55;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cnt_clr = (c == 4);
            cycle();
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL clr c%0d got %h want %h",
                         c, obs(), m_exp);
            end
            if (c == 4) begin
                n_vec++;
                if (pat_cnt !== 8'd0) begin
                    n_err++;
                    $display("FAIL clr_edge got %0d want 0", pat_cnt);
                end
            end
        end
        cnt_clr = 1'b0;
        n_vec++;
        if (pat_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL clr_after got %0d want 1", pat_cnt);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] words [3];
        logic [3:0] sh;
        int det, idx;
        logic a;
        words[0] = 8'h5A;
        words[1] = 8'h05;
        words[2] = 8'hA5;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        sh = '0;
        det = 0;
        idx = 0;
        din = words[0];
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            sh = {sh[2:0], dataout};
            if (sh == 4'b0101) det++;
            a = in_valid && in_ready;
            cycle();
            if (a) begin
                idx++;
                if (idx < 3) din = words[idx];
                else in_valid = 1'b0;
            end
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL loop c%0d got %h want %h",
                         c, obs(), m_exp);
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (det !== 3 || pat_cnt !== 8'(det)) begin
            n_err++;
            $display("FAIL loop_cnt got det=%0d pat=%0d want 3/3",
                     det, pat_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                din = 8'($urandom);
            end
            cnt_clr = ($urandom_range(0, 31) == 0);
            cycle();
            n_vec++;
            if (obs() !== m_exp) begin
                n_err++;
                $display("FAIL rand c%0d got %h want %h",
                         c, obs(), m_exp);
            end
        end
        in_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        calc_exp();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_sat_clear();
        test_loopback();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
